// File: rtl/context_window_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : context_window_streamer_if
//  Purpose  : Bundles the start/status, row-RAM read port and window
//             valid/ready handshake of the context window streamer.
//  Revision : 1.0  initial release
// ============================================================================
interface context_window_streamer_if #(
    parameter int DW    = 16,
    parameter int ROWS  = 3,
    parameter int WIN_W = 3,
    parameter int AW    = 6
);
    logic                        start;
    logic                        pad_mode;
    logic                        busy;
    logic                        ram_rd_en;
    logic [AW-1:0]               ram_addr;
    logic [ROWS*DW-1:0]          ram_rdata;
    logic [ROWS*WIN_W*DW-1:0]    win_data;
    logic                        win_valid;
    logic                        win_ready;
    logic [AW-1:0]               win_col;
    logic                        line_done;

    // Streamer side
    modport slave (
        input  start, pad_mode, ram_rdata, win_ready,
        output busy, ram_rd_en, ram_addr, win_data, win_valid, win_col, line_done
    );

    // Controller / RAM / encoder side
    modport master (
        output start, pad_mode, ram_rdata, win_ready,
        input  busy, ram_rd_en, ram_addr, win_data, win_valid, win_col, line_done
    );
endinterface
`default_nettype wire

// File: rtl/context_window_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : context_window_streamer
//  Purpose  : Reads ROWS parallel line RAMs column by column, assembles a
//             ROWS x WIN_W context window and presents it over valid/ready,
//             with optional edge-replicate padding and a per-line done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module context_window_streamer #(
    parameter int DW       = 16,
    parameter int ROWS     = 3,
    parameter int WIN_W    = 3,
    parameter int LINE_LEN = 25,
    parameter int AW       = 6
) (
    input wire                      clk,
    input wire                      rst_n,
    context_window_streamer_if.slave bus
);
    localparam int H  = (WIN_W - 1) / 2;
    localparam int CW = $clog2(LINE_LEN + WIN_W + 1);
    localparam int WD = ROWS * WIN_W * DW;

    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [CW-1:0] c_PRIME    = CW'(WIN_W);
    localparam logic [CW-1:0] c_NRD_PAD  = CW'(LINE_LEN + 2 * H);
    localparam logic [CW-1:0] c_NRD_RAW  = CW'(LINE_LEN);
    localparam logic [CW-1:0] c_NWIN_PAD = CW'(LINE_LEN);
    localparam logic [CW-1:0] c_NWIN_RAW = CW'(LINE_LEN - WIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_pad;
    logic            r_cap;      // read data is on ram_rdata this cycle
    logic            r_valid;
    logic            r_done;
    logic [CW-1:0]   r_rd_cnt;   // reads issued this line
    logic [CW-1:0]   r_acc_cnt;  // windows accepted this line
    logic [AW-1:0]   r_col;
    logic [WD-1:0]   r_win;

    logic [CW-1:0]   w_nrd;
    logic [CW-1:0]   w_nwin;
    logic            w_accept;
    logic            w_last;
    logic            w_rd_en;
    logic [AW-1:0]   w_addr;
    logic [WD-1:0]   w_win_next;
    int              w_idx;

    assign w_nrd    = r_pad ? c_NRD_PAD  : c_NRD_RAW;
    assign w_nwin   = r_pad ? c_NWIN_PAD : c_NWIN_RAW;
    assign w_accept = (r_state == S_RUN) && r_valid && bus.win_ready;
    assign w_last   = (r_acc_cnt == (w_nwin - c_ONE));

    // Priming reads back-to-back; afterwards one read per accepted window so the
    // next column arrives one cycle after the accept (2 cycles per window).
    assign w_rd_en  = ((r_state == S_PRIME) && (r_rd_cnt < c_PRIME)) ||
                      (w_accept && !w_last && (r_rd_cnt < w_nrd));

    // Address of the next read, clamped so it never leaves the line.
    always_comb begin
        w_idx = int'(r_rd_cnt);
        if (r_pad) begin
            w_idx = w_idx - H;
        end
        if (w_idx < 0) begin
            w_idx = 0;
        end
        if (w_idx > LINE_LEN - 1) begin
            w_idx = LINE_LEN - 1;
        end
        w_addr = AW'(w_idx);
    end

    // Shift every row one column toward k=0 and insert the returned column at the right.
    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < WIN_W; k++) begin
                if (k < WIN_W - 1) begin
                    w_win_next[(r*WIN_W+k)*DW +: DW] = r_win[(r*WIN_W+k+1)*DW +: DW];
                end else begin
                    w_win_next[(r*WIN_W+k)*DW +: DW] = bus.ram_rdata[r*DW +: DW];
                end
            end
        end
    end

    // Line sequencing FSM with registered handshake outputs and window storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pad     <= 1'b0;
            r_cap     <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_rd_cnt  <= '0;
            r_acc_cnt <= '0;
            r_col     <= '0;
            r_win     <= '0;
        end else begin
            r_done <= 1'b0;
            r_cap  <= w_rd_en;
            if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + c_ONE;
            end
            if (r_cap) begin
                r_win <= w_win_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_PRIME;
                        r_pad     <= bus.pad_mode;
                        r_rd_cnt  <= '0;
                        r_acc_cnt <= '0;
                        r_col     <= bus.pad_mode ? '0 : AW'(H);
                    end
                end
                S_PRIME: begin
                    if (r_cap && !w_rd_en) begin
                        r_state <= S_RUN;
                        r_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cap) begin
                        r_valid <= 1'b1;
                    end
                    if (w_accept) begin
                        r_valid   <= 1'b0;
                        r_acc_cnt <= r_acc_cnt + c_ONE;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_col <= r_col + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.ram_rd_en = w_rd_en;
    assign bus.ram_addr  = w_addr;
    assign bus.win_data  = r_win;
    assign bus.win_valid = r_valid;
    assign bus.win_col   = r_col;
    assign bus.line_done = r_done;
endmodule
`default_nettype wire
